// File: rtl/dac_arbiter.sv
// dac_arbiter: shares one DAC SPI master among NUM_REQ requesters.
// Round-robin arbitration with optional grant lock, per-requester enable mask.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_arm            per-requester transaction request
//   req_to_dac         packed command words, requester i at [i*DAC_WID +: DAC_WID]
//   req_lock           keep grant after the current transaction
//   req_enable         mask; disabled requesters are never newly granted
//   req_from_dac       registered response of the last completed transaction
//   req_finished       one-hot completion flag to the owner
//   grant              one-hot current owner, zero when unowned
//   spi_arm            arm to the SPI master
//   spi_to_dac         command word to the SPI master
//   spi_from_dac       response word from the SPI master
//   spi_finished       SPI master done, held until spi_arm falls
module dac_arbiter #(
    parameter int DAC_WID = 24,
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_arm,
    input  logic [NUM_REQ*DAC_WID-1:0] req_to_dac,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ-1:0]         req_enable,
    output logic [DAC_WID-1:0]         req_from_dac,
    output logic [NUM_REQ-1:0]         req_finished,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       spi_arm,
    output logic [DAC_WID-1:0]         spi_to_dac,
    input  logic [DAC_WID-1:0]         spi_from_dac,
    input  logic                       spi_finished
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      last_owner;

    logic [NUM_REQ-1:0] cand;
    logic               locked;
    logic               sel_valid;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      rr_idx;

    assign cand = req_arm & req_enable;

    // A retained grant only counts as a lock while the owner still asks for
    // it and is still enabled; otherwise arbitration reopens this cycle.
    assign locked = (grant != '0) && req_lock[owner] && req_enable[owner];

    // Walk offsets from far to near so the nearest candidate after
    // last_owner is the one left standing.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        rr_idx    = '0;
        if (locked) begin
            if (req_arm[owner]) begin
                sel_valid = 1'b1;
                sel_idx   = owner;
            end
        end else begin
            for (int i = NUM_REQ; i >= 1; i--) begin
                rr_idx = IW'((32'(last_owner) + 32'(i)) % NUM_REQ);
                if (cand[rr_idx]) begin
                    sel_valid = 1'b1;
                    sel_idx   = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= '0;
            last_owner   <= IW'(NUM_REQ - 1);
            spi_arm      <= 1'b0;
            spi_to_dac   <= '0;
            req_from_dac <= '0;
            req_finished <= '0;
            grant        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner      <= sel_idx;
                        grant      <= ONE << sel_idx;
                        spi_to_dac <= req_to_dac[sel_idx*DAC_WID +: DAC_WID];
                        spi_arm    <= 1'b1;
                        state      <= ISSUE;
                    end else if (!locked) begin
                        grant <= '0;
                    end
                end
                ISSUE: begin
                    // The owner dropping req_arm here does not abort the
                    // SPI transfer; it just shortens RESPOND to one cycle.
                    if (spi_finished) begin
                        req_from_dac <= spi_from_dac;
                        spi_arm      <= 1'b0;
                        req_finished <= ONE << owner;
                        state        <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!req_arm[owner]) begin
                        req_finished <= '0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait for the SPI master to see spi_arm low before
                    // another transaction may be armed.
                    if (!spi_finished) begin
                        last_owner <= owner;
                        if (!req_lock[owner]) begin
                            grant <= '0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
